cell_link_merge_arbiter: RTL

- Packet-mode merge of two non-backpressurable AXI-Stream sources: incoming cell link (S00) and local BPM data (S01).
- Produces one outgoing stream feeding the cell-link forwarder's header/bitmap logic.
- Each input has its own packet-mode FIFO. Only complete packets are eligible. A round-robin arbiter grants one whole packet at a time.
- In-house replacement for the vendor AXIS interconnect used for the forwarding merge.

---
 rtl/cell_link_merge_arbiter_pkg.sv | 18 +
 rtl/cell_link_merge_arbiter_if.sv | 40 ++++
 rtl/cell_link_merge_arbiter_packet_fifo.sv | 78 +++++++
 rtl/cell_link_merge_arbiter.sv | 114 +++++++++++
 4 files changed

// File: rtl/cell_link_merge_arbiter_pkg.sv
// rtl/cell_link_merge_arbiter_pkg.sv - shared types and defaults for the cell-link merge arbiter
package cell_link_merge_arbiter_pkg;

    typedef enum logic {
        SRC_CELL  = 1'b0,
        SRC_LOCAL = 1'b1
    } srcT;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arbStateT;

    localparam int DEFAULT_FIFO_AW = 8;
    localparam int DEFAULT_DATA_W  = 32;
    localparam int DEFAULT_CNT_W   = 8;

endpackage

// File: rtl/cell_link_merge_arbiter_if.sv
// rtl/cell_link_merge_arbiter_if.sv - stream and status bundle for the cell-link merge arbiter
interface cell_link_merge_arbiter_if
    import cell_link_merge_arbiter_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = DEFAULT_CNT_W
);
    logic              s00TVALID;
    logic              s00TLAST;
    logic [DATA_W-1:0] s00TDATA;
    logic              s01TVALID;
    logic              s01TLAST;
    logic [DATA_W-1:0] s01TDATA;
    logic              s00Suppress;
    logic              s01Suppress;
    logic              mTVALID;
    logic              mTREADY;
    logic              mTLAST;
    logic [DATA_W-1:0] mTDATA;
    logic              mTSOURCE;
    logic [CNT_W-1:0]  s00DropCount;
    logic [CNT_W-1:0]  s01DropCount;

    modport slave (
        input  s00TVALID, s00TLAST, s00TDATA,
        input  s01TVALID, s01TLAST, s01TDATA,
        input  s00Suppress, s01Suppress, mTREADY,
        output mTVALID, mTLAST, mTDATA, mTSOURCE,
        output s00DropCount, s01DropCount
    );

    modport master (
        output s00TVALID, s00TLAST, s00TDATA,
        output s01TVALID, s01TLAST, s01TDATA,
        output s00Suppress, s01Suppress, mTREADY,
        input  mTVALID, mTLAST, mTDATA, mTSOURCE,
        input  s00DropCount, s01DropCount
    );

endinterface

// File: rtl/cell_link_merge_arbiter_packet_fifo.sv
// rtl/cell_link_merge_arbiter_packet_fifo.sv - packet-mode FIFO with speculative write, commit and drop counting
module merge_packet_fifo
    import cell_link_merge_arbiter_pkg::*;
#(
    parameter int FIFO_AW = DEFAULT_FIFO_AW,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              wrValid,
    input  logic              wrLast,
    input  logic [DATA_W-1:0] wrData,
    input  logic              rdEn,
    output logic              pktAvail,
    output logic [DATA_W-1:0] rdData,
    output logic              rdLast,
    output logic [CNT_W-1:0]  dropCount
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_FULL = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0] PTR_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [FIFO_AW:0] wrPtr;
    logic [FIFO_AW:0] commitPtr;
    logic [FIFO_AW:0] rdPtr;
    logic             dropping;
    logic             full;
    logic             wrAccept;
    logic             overflow;
    logic [DATA_W:0]  mem [DEPTH];

    assign full     = (wrPtr - rdPtr) == PTR_FULL;
    assign wrAccept = wrValid && !dropping && !full;
    assign overflow = wrValid && !dropping && full;
    assign pktAvail = (commitPtr != rdPtr);
    assign {rdLast, rdData} = mem[rdPtr[FIFO_AW-1:0]];

    always_ff @(posedge clk) begin
        if (wrAccept) begin
            mem[wrPtr[FIFO_AW-1:0]] <= {wrLast, wrData};
        end
    end

    // Overflow rewinds to the last commit so earlier packets stay intact; an
    // overflowing TLAST word ends the packet on the spot, so no drop state is kept.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wrPtr     <= '0;
            commitPtr <= '0;
            rdPtr     <= '0;
            dropping  <= 1'b0;
            dropCount <= '0;
        end else begin
            if (rdEn) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
            if (wrValid && dropping) begin
                if (wrLast) begin
                    dropping <= 1'b0;
                end
            end else if (overflow) begin
                wrPtr    <= commitPtr;
                dropping <= !wrLast;
                if (dropCount != '1) begin
                    dropCount <= dropCount + CNT_ONE;
                end
            end else if (wrAccept) begin
                wrPtr <= wrPtr + PTR_ONE;
                if (wrLast) begin
                    commitPtr <= wrPtr + PTR_ONE;
                end
            end
        end
    end

endmodule

// File: rtl/cell_link_merge_arbiter.sv
// rtl/cell_link_merge_arbiter.sv - round-robin whole-packet merge of cell-link and local BPM streams
module cell_link_merge_arbiter
    import cell_link_merge_arbiter_pkg::*;
#(
    parameter int FIFO_AW = DEFAULT_FIFO_AW,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic                     auroraUserClk,
    input  logic                     auroraUserResetN,
    cell_link_merge_arbiter_if.slave bus
);
    logic              pktAvail0, pktAvail1;
    logic              rdEn0, rdEn1;
    logic              rdLast0, rdLast1;
    logic [DATA_W-1:0] rdData0, rdData1;
    logic [CNT_W-1:0]  dropCount0, dropCount1;

    arbStateT          state, stateNext;
    srcT               lastGrant, curSrc, grantSrc, rdSel;
    logic              elig0, elig1, anyElig;
    logic              load, loadLast;
    logic [DATA_W-1:0] loadData;
    logic              mValid, mLast;
    logic [DATA_W-1:0] mData;

    merge_packet_fifo #(.FIFO_AW(FIFO_AW), .DATA_W(DATA_W), .CNT_W(CNT_W)) u_fifoCell (
        .clk(auroraUserClk), .rstN(auroraUserResetN),
        .wrValid(bus.s00TVALID), .wrLast(bus.s00TLAST), .wrData(bus.s00TDATA),
        .rdEn(rdEn0), .pktAvail(pktAvail0), .rdData(rdData0), .rdLast(rdLast0),
        .dropCount(dropCount0)
    );

    merge_packet_fifo #(.FIFO_AW(FIFO_AW), .DATA_W(DATA_W), .CNT_W(CNT_W)) u_fifoLocal (
        .clk(auroraUserClk), .rstN(auroraUserResetN),
        .wrValid(bus.s01TVALID), .wrLast(bus.s01TLAST), .wrData(bus.s01TDATA),
        .rdEn(rdEn1), .pktAvail(pktAvail1), .rdData(rdData1), .rdLast(rdLast1),
        .dropCount(dropCount1)
    );

    always_ff @(posedge auroraUserClk or negedge auroraUserResetN) begin
        if (!auroraUserResetN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (anyElig) stateNext = XFER;
            XFER:    if (mValid && bus.mTREADY && mLast) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // The first word is loaded on the grant edge itself, keeping commit-to-valid at two cycles.
    always_comb begin
        elig0    = pktAvail0 && !bus.s00Suppress;
        elig1    = pktAvail1 && !bus.s01Suppress;
        anyElig  = elig0 || elig1;
        if (elig0 && elig1) begin
            grantSrc = (lastGrant == SRC_CELL) ? SRC_LOCAL : SRC_CELL;
        end else begin
            grantSrc = elig1 ? SRC_LOCAL : SRC_CELL;
        end
        load  = 1'b0;
        rdSel = curSrc;
        case (state)
            IDLE: begin
                load  = anyElig;
                rdSel = grantSrc;
            end
            XFER:    load = mValid && bus.mTREADY && !mLast;
            default: load = 1'b0;
        endcase
        rdEn0    = load && (rdSel == SRC_CELL);
        rdEn1    = load && (rdSel == SRC_LOCAL);
        loadData = (rdSel == SRC_LOCAL) ? rdData1 : rdData0;
        loadLast = (rdSel == SRC_LOCAL) ? rdLast1 : rdLast0;
    end

    always_ff @(posedge auroraUserClk or negedge auroraUserResetN) begin
        if (!auroraUserResetN) begin
            mValid    <= 1'b0;
            mLast     <= 1'b0;
            mData     <= '0;
            curSrc    <= SRC_CELL;
            lastGrant <= SRC_LOCAL;
        end else begin
            if (state == IDLE && anyElig) begin
                lastGrant <= grantSrc;
                curSrc    <= grantSrc;
            end
            if (load) begin
                mValid <= 1'b1;
                mLast  <= loadLast;
                mData  <= loadData;
            end else if (mValid && bus.mTREADY) begin
                mValid <= 1'b0;
                mLast  <= 1'b0;
            end
        end
    end

    assign bus.mTVALID      = mValid;
    assign bus.mTLAST       = mLast;
    assign bus.mTDATA       = mData;
    assign bus.mTSOURCE     = curSrc;
    assign bus.s00DropCount = dropCount0;
    assign bus.s01DropCount = dropCount1;

endmodule
